// File: rtl/result_display.sv
// ---------------------------------------------------------------------------
// result_display
//
// Shows the calculator's selected 32-bit result on six active-low
// seven-segment digits. A sequential double-dabble engine converts one
// binary bit per clock into BCD. The display supports:
//   - a leading minus sign in signed mode,
//   - blanking of leading zeros,
//   - all-minus overflow when the value does not fit in six digits.
// The outputs change only once a conversion completes. An input that changes
// while a conversion is in flight is picked up by the next conversion.
//
// Ports
//   clk          in   1   system clock
//   reset        in   1   asynchronous, active-high
//   value_in     in  32   result to display
//   signed_mode  in   1   1: value_in is two's complement, 0: unsigned
//   hex5..hex0   out  7   segment drives {g,f,e,d,c,b,a}, active-low;
//                         hex0 is the least significant digit
//   busy         out  1   high while the BCD engine is shifting
//   done         out  1   one-cycle pulse after the hex outputs update
// ---------------------------------------------------------------------------
module result_display (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] value_in,
    input  logic        signed_mode,
    output logic [6:0]  hex5,
    output logic [6:0]  hex4,
    output logic [6:0]  hex3,
    output logic [6:0]  hex2,
    output logic [6:0]  hex1,
    output logic [6:0]  hex0,
    output logic        busy,
    output logic        done
);

    localparam int         DIGITS    = 6;
    localparam int         BIN_W     = 20;          // 999999 fits in 20 bits
    localparam int         BCD_W     = 4 * DIGITS;
    localparam logic [4:0] LAST_BIT  = 5'(BIN_W - 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        LOAD
    } state_t;

    // Active-low seven-segment code for one BCD digit.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Double-dabble correction for one nibble. The result is at most 12, so
    // it never carries out of the nibble.
    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = add3(b[4*i +: 4]);
        end
        return r;
    endfunction

    state_t            state;
    logic              pending;
    logic [31:0]       cap_value;
    logic              cap_mode;
    logic [4:0]        cnt;

    logic [BIN_W-1:0]  shift_r;
    logic [BCD_W-1:0]  bcd_r;
    logic              neg_r;
    logic              ovf_r;

    logic              trigger;
    logic              neg_in;
    logic [31:0]       mag_in;
    logic              ovf_in;
    logic [6:0]        disp [DIGITS];

    // ---- input qualification: sign, magnitude and range of the live input
    always_comb begin
        neg_in  = signed_mode & value_in[31];
        // 32-bit wrap: -2^31 yields 2^31, which lands in the overflow range.
        mag_in  = neg_in ? (32'd0 - value_in) : value_in;
        // A negative value gives up hex5 to the minus sign, so it has only
        // five digits available.
        ovf_in  = neg_in ? (mag_in > 32'd99999) : (mag_in > 32'd999999);
        trigger = (state == IDLE) &&
                  (pending || ({signed_mode, value_in} != {cap_mode, cap_value}));
    end

    // ---- display formatting from the finished BCD digits
    always_comb begin
        logic       seen;
        logic [3:0] digit;
        seen  = 1'b0;
        digit = 4'd0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            digit = bcd_r[4*i +: 4];
            // Everything at or below the first non-zero digit is shown.
            // hex0 is always shown, so that zero displays as "0".
            if (digit != 4'd0 || i == 0) begin
                seen = 1'b1;
            end
            disp[i] = seen ? seg7(digit) : SEG_BLANK;
        end
        if (neg_r) begin
            disp[DIGITS-1] = SEG_MINUS;
        end
        if (ovf_r) begin
            for (int i = 0; i < DIGITS; i++) begin
                disp[i] = SEG_MINUS;
            end
        end
    end

    // ---- control FSM and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pending   <= 1'b1;      // forces one conversion after reset release
            cap_value <= 32'd0;
            cap_mode  <= 1'b0;
            cnt       <= 5'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            hex5      <= SEG_BLANK;
            hex4      <= SEG_BLANK;
            hex3      <= SEG_BLANK;
            hex2      <= SEG_BLANK;
            hex1      <= SEG_BLANK;
            hex0      <= SEG_BLANK;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (trigger) begin
                        cap_value <= value_in;
                        cap_mode  <= signed_mode;
                        pending   <= 1'b0;
                        cnt       <= 5'd0;
                        // Overflow skips the BCD engine; the display is all minus.
                        state     <= ovf_in ? LOAD : CONVERT;
                    end
                end
                CONVERT: begin
                    busy <= 1'b1;
                    cnt  <= cnt + 5'd1;
                    if (cnt == LAST_BIT) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    hex5  <= disp[5];
                    hex4  <= disp[4];
                    hex3  <= disp[3];
                    hex2  <= disp[2];
                    hex1  <= disp[1];
                    hex0  <= disp[0];
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // ---- BCD datapath: loaded on trigger, shifts one bit per CONVERT cycle
    always_ff @(posedge clk) begin
        if (trigger) begin
            neg_r   <= neg_in;
            ovf_r   <= ovf_in;
            shift_r <= mag_in[BIN_W-1:0];
            bcd_r   <= '0;
        end else if (state == CONVERT) begin
            {bcd_r, shift_r} <= {bcd_adjust(bcd_r), shift_r} << 1;
        end
    end

endmodule

// File: doc/result_display.md
# result_display

Downstream consumer of the calculator's selected 32-bit result. Converts the value to decimal with a sequential double-dabble engine and drives six active-low seven-segment digits (HEX5..HEX0), with sign, leading-zero blanking and overflow indication. Sits beside the 10-bit LED output in the FPGA top, fed by the result selector output and the switch-selected signedness.

## Interface
- No parameters; digit count fixed at 6, segment polarity fixed active-low, bit order {g,f,e,d,c,b,a}.
- Reset behaviour (already decided): reset reset, asynchronous, active-high; clock clk.
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- value_in  in  32  result to display
- signed_mode  in  1  1: value_in is two's complement; 0: unsigned
- hex5..hex0  out  7 each  segment drives; hex0 is the least significant digit
- busy  out  1  high while a conversion is in progress
- done  out  1  one-cycle pulse when the hex outputs have just been updated

## Operation
- FSM states: IDLE, CONVERT, LOAD.
- IDLE conversion trigger: pending flag set, or {signed_mode,value_in} differs from captured {cap_mode,cap_value}.
  - On trigger: capture mode and value; clear pending.
  - Compute neg = signed_mode & value_in[31], and mag = neg ? -value_in : value_in as a 32-bit unsigned.
  - ovf = neg ? (mag > 99999) : (mag > 999999).
  - If ovf, go to LOAD. Otherwise load shift reg[19:0] = mag[19:0], clear BCD (24 bits), cnt = 0, go to CONVERT.
- CONVERT, one bit per cycle, 20 cycles:
  - For each BCD nibble, if the nibble is >= 5, add 3.
  - Then shift {bcd, shift} left by 1.
  - cnt increments; after cnt == 19 the next state is LOAD.
- LOAD (one cycle): register the new hex outputs, pulse done, return to IDLE.
- Display rules:
  - ovf: all six digits show minus (0111111).
  - Otherwise, digits above the most significant non-zero digit are blank (1111111). hex0 always shows a digit, so a value of 0 shows "0".
  - If neg, hex5 shows minus regardless of blanking. neg cannot coexist with a non-zero digit 5, by the ovf limit.
- Segment codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Arithmetic widths:
  - Negation is 32-bit wrap, so -2^31 gives mag = 2^31, which is ovf.
  - mag <= 999999 fits 20 bits; BCD is 6 nibbles; nibble add-3 never carries out.

## Timing
- Reset: hex5..hex0 = 1111111 (blank), busy = 0, done = 0, state IDLE, pending = 1, cap_value = 0, cap_mode = 0. Forces one conversion after reset release.
- Latency, non-overflow: trigger sampled at edge N; CONVERT occupies edges N+1..N+20; outputs and done change at edge N+21; done is high for the cycle after N+21.
- Latency, overflow: outputs update at edge N+1.
- busy is high from the edge after the trigger until the LOAD edge; it is low in IDLE.
- Input changes during CONVERT/LOAD are ignored. On return to IDLE, the compare against the captured value retriggers, so the last stable input is always eventually displayed. No intermediate results are output.
- Hex outputs hold their last value during conversion (no flicker).
- Unchanged input: remains in IDLE indefinitely; done stays 0.
- Reset asserted mid-conversion: immediate abort to the reset values; reconverts after release.

## Test plan
- Reset, then value_in = 0, signed_mode = 0 -> hex outputs blank during reset; 22 cycles after release hex0 = 1000000, hex5..hex1 blank, one done pulse.
- value_in = 123456, unsigned -> hex5..hex0 = 1,2,3,4,5,6 codes exactly 21 edges after the change; busy high for 20 cycles.
- value_in = 0xFFFFFFD6, signed_mode = 1 -> hex5 = 0111111 (minus), hex1 = 4, hex0 = 2, hex4..hex2 blank. Toggle signed_mode to 0 -> retrigger, all six = minus (overflow), updated 1 edge after the trigger.
- Overflow boundaries:
  - unsigned 999999 -> digits 999999; unsigned 1000000 -> all minus.
  - signed -99999 -> minus, 99999; signed -100000 -> all minus.
  - signed 0x80000000 -> all minus.
- Change value_in from 5 to 77 at CONVERT cycle 10, then hold -> display shows 5 first (done pulse), then 77 after a second conversion; exactly two done pulses.
- Assert reset at CONVERT cycle 7 -> outputs blank immediately, busy = 0; after release, the current value is displayed after 22 cycles.
